// File: rtl/awgn_pkg.sv
// Shared types and widths for the AWGN Box-Muller datapath.
package awgn_pkg;

    localparam int U0_W  = 48;
    localparam int EXP_W = 6;

    // Sequencing states of the u0 normaliser controller.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } norm_state_e;

endpackage

// File: rtl/lzc_chunk.sv
// Combinational leading-zero count of one CHUNK-bit slice.
// lz is CHUNK when the slice is all zeros; nz flags a nonzero slice.
module lzc_chunk #(
    parameter int CHUNK = 8,
    parameter int LZ_W  = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] chunk,
    output logic             nz,
    output logic [LZ_W-1:0]  lz
);

    // Walk from LSB to MSB so the highest set bit determines the count.
    always_comb begin
        // NOTE: every output gets a value before any condition, so no latch is inferred.
        nz = |chunk;
        lz = LZ_W'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            if (chunk[i]) begin
                lz = LZ_W'(CHUNK - 1 - i);
            end
        end
    end

endmodule

// File: rtl/u0_norm_ctrl.sv
// Normaliser controller for u0: accepts a sample, scans for the leading one
// one chunk per cycle, shifts it out, and returns {x_e, exp_e}.
module u0_norm_ctrl
    import awgn_pkg::*;
#(
    parameter int W     = U0_W,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     u0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     x_e,
    output logic [EXP_W-1:0] exp_e,
    output logic             zero_flag,
    output logic             busy
);

    localparam int NCH   = W / CHUNK;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LZ_W  = $clog2(CHUNK + 1);

    norm_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     sample_q, sample_d;
    logic [W-1:0]     x_e_q, x_e_d;
    logic [EXP_W-1:0] exp_e_q, exp_e_d;
    logic             zero_flag_q, zero_flag_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [W-1:0]     scan_word;
    logic [CHUNK-1:0] chunk;
    logic             chunk_nz;
    logic [LZ_W-1:0]  chunk_lz;

    // Bring chunk cnt to the top of the word so it can be taken as a fixed slice.
    assign scan_word = sample_q << (int'(cnt_q) * CHUNK);
    assign chunk     = scan_word[W-1 -: CHUNK];

    lzc_chunk #(
        .CHUNK (CHUNK),
        .LZ_W  (LZ_W)
    ) u_lzc (
        .chunk (chunk),
        .nz    (chunk_nz),
        .lz    (chunk_lz)
    );

    // Next-state and datapath updates; everything holds unless a state acts on it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sample_d    = sample_q;
        x_e_d       = x_e_q;
        exp_e_d     = exp_e_q;
        zero_flag_d = zero_flag_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sample_d = u0;
                    cnt_d    = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (chunk_nz) begin
                    exp_e_d = EXP_W'(int'(cnt_q) * CHUNK + int'(chunk_lz) + 1);
                    state_d = SHIFT;
                end else if (int'(cnt_q) == NCH - 1) begin
                    exp_e_d     = '0;
                    zero_flag_d = 1'b1;
                    state_d     = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                // exp_e == 48 shifts the whole word out; exp_e == 0 passes a zero sample.
                x_e_d   = sample_q << exp_e_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    zero_flag_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered copies of the upcoming state.
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sample_q    <= '0;
            x_e_q       <= '0;
            exp_e_q     <= '0;
            zero_flag_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sample_q    <= sample_d;
            x_e_q       <= x_e_d;
            exp_e_q     <= exp_e_d;
            zero_flag_q <= zero_flag_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign x_e       = x_e_q;
    assign exp_e     = exp_e_q;
    assign zero_flag = zero_flag_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_u0_norm_ctrl.sv
// Self-checking bench for u0_norm_ctrl (CHUNK = 8): directed corner cases,
// back-pressure, reset abort, then randomized samples against a bit-level model.
module tb_u0_norm_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] u0;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] x_e;
    logic [5:0]  exp_e;
    logic        zero_flag;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    u0_norm_ctrl #(.W(48), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .u0        (u0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_e       (x_e),
        .exp_e     (exp_e),
        .zero_flag (zero_flag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: find the highest set bit, shift it out, latency from its chunk index.
    task automatic model(input logic [47:0] v, output logic [5:0] e, output logic [47:0] x,
                         output bit z, output int lat);
        logic [63:0] wide;
        int pos;
        pos = -1;
        for (int b = 0; b < 48; b++) begin
            if (v[b]) pos = b;
        end
        if (pos < 0) begin
            z   = 1'b1;
            e   = 6'd0;
            x   = 48'd0;
            lat = 5 + 2;
        end else begin
            z    = 1'b0;
            e    = 6'(48 - pos);
            wide = {16'd0, v} << (48 - pos);
            x    = wide[47:0];
            lat  = ((47 - pos) / 8) + 2;
        end
    endtask

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[47:0];
    endfunction

    // One full transaction: accept, time the scan, hold under back-pressure, hand off.
    task automatic run_txn(input logic [47:0] val, input int hold, input bit noisy);
        logic [5:0]  e_exp;
        logic [47:0] x_exp;
        bit          z_exp;
        int          lat_exp;
        int          n;
        int          guard;
        bit          ready_leak;
        bit          stable_ok;
        model(val, e_exp, x_exp, z_exp, lat_exp);

        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);

        in_valid = 1'b1;
        u0       = val;
        @(posedge clk); #1;
        in_valid = 1'b0;
        u0       = rand48();

        n = 0;
        ready_leak = 1'b0;
        while (!out_valid && n < 60) begin
            if (in_ready) ready_leak = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(lat_exp));
        check("in_ready_low_while_busy", 64'(ready_leak | in_ready), 64'd0);
        check("exp_e", 64'(exp_e), 64'(e_exp));
        check("x_e", 64'(x_e), 64'(x_exp));
        check("zero_flag", 64'(zero_flag), 64'(z_exp));
        check("busy_done", 64'(busy), 64'd1);

        stable_ok = 1'b1;
        for (int c = 0; c < hold; c++) begin
            if (noisy) begin
                in_valid = 1'b1;
                u0       = rand48();
            end
            @(posedge clk); #1;
            if (!out_valid || in_ready || x_e !== x_exp || exp_e !== e_exp || zero_flag !== z_exp)
                stable_ok = 1'b0;
        end
        if (hold > 0) check("held_stable", 64'(stable_ok), 64'd1);
        in_valid = 1'b0;

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
        check("in_ready_after_hs", 64'(in_ready), 64'd1);
        check("zero_flag_after_hs", 64'(zero_flag), 64'd0);
        check("exp_e_held_after_hs", 64'(exp_e), 64'(e_exp));
        check("x_e_held_after_hs", 64'(x_e), 64'(x_exp));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_x_e"}, 64'(x_e), 64'd0);
        check({tag, "_exp_e"}, 64'(exp_e), 64'd0);
        check({tag, "_zero_flag"}, 64'(zero_flag), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [47:0] v;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        u0        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("reset");

        // Directed corners: MSB, mid value, LSB only, zero.
        run_txn(48'h8000_0000_0000, 0, 1'b0);
        check("msb_exp_e_const", 64'(exp_e), 64'd1);
        run_txn(48'h0001_2345_6789, 0, 1'b0);
        check("mid_x_e_const", 64'(x_e), 64'h2345_6789_0000);
        run_txn(48'h0000_0000_0001, 0, 1'b0);
        check("lsb_exp_e_const", 64'(exp_e), 64'd48);
        run_txn(48'h0000_0000_0000, 0, 1'b0);

        // Back-pressure: ten cycles of out_ready low with competing in_valid.
        run_txn(48'h0000_00F0_0000, 10, 1'b1);

        // Abort during SCAN: leading one in chunk 4, reset after one scan cycle.
        in_valid = 1'b1;
        u0       = 48'h0000_0000_0100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("busy_in_scan", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("after_abort");

        // Randomized samples spread across all chunk positions.
        for (int t = 0; t < 40; t++) begin
            v = rand48();
            v = v >> $urandom_range(0, 48);
            if ($urandom_range(0, 9) == 0) v = '0;
            run_txn(v, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
